pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline register for the core's inter-stage boundaries (EX/MEM, MEM/WB and successors). It replaces fixed single-entry stage registers with a STAGES-deep chain that has per-entry valid, valid/ready backpressure, bubble collapsing and a synchronous flush. Every empty entry carries all-zero control, so an empty entry is a NOP downstream. Optionally, a skid entry registers the upstream ready path.

## Interface
- DATA_W, 32, width of the datapath payload (ALU result, load data, PC, ...)
- CTRL_W, 8, width of the control payload (write-back select, rd write enable, rd address, ...); forced to zero in empty entries
- STAGES, 1, number of register entries in the chain; legal range 1..4
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  kill all in-flight entries (branch/exception squash)
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  block accepts an entry this cycle
- in_ctrl_i  in  CTRL_W  upstream control payload
- in_data_i  in  DATA_W  upstream data payload
- out_valid_o  out  1  last entry valid
- out_ready_i  in  1  downstream accepts the last entry
- out_ctrl_o  out  CTRL_W  last entry control; 0 whenever out_valid_o=0
- out_data_o  out  DATA_W  last entry data; 0 whenever out_valid_o=0
- occ_o  out  $clog2(STAGES+2)  number of valid entries, including the skid entry

## Operation
- Entries are numbered 0 (input side) to STAGES-1 (output side). Each entry holds {v, ctrl, data}.
- Advance rule: entry STAGES-1 is free when it is empty or out_ready_i=1. Entry k<STAGES-1 is free when it is empty or entry k+1 is free. A free entry loads from its predecessor, or from the input for entry 0.
- Bubble collapse: a valid entry moves forward whenever its successor is free, even while downstream is stalled.
- When an entry loads from an empty predecessor, it becomes v=0, ctrl=0, data=0.
- Transfers:
  - input handshake = in_valid_i & in_ready_o
  - output handshake = out_valid_o & out_ready_i
  - Order is preserved. No entry is lost or duplicated.
- Without skid: in_ready_o = !flush_i & (entry 0 free). This is a combinational path from out_ready_i.
- Flush:
  - flush_i=1 forces in_ready_o=0.
  - The next edge clears every entry (v, ctrl, data = 0) and the skid entry.
  - An output handshake in the flush cycle still completes; the entry shown is consumed normally.
- Reset (rst_ni=0 at an edge) has priority over flush and handshakes.
  - All entries and the skid entry are cleared.
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0.
  - in_ready_o=1 once rst_ni=1 (with flush_i=0).
  - Reset mid-stream discards all in-flight entries; there is no partial drain.
- in_ctrl_i/in_data_i are don't-care when in_valid_i=0. They are never captured in that case.

## Timing
- Latency: an entry accepted at edge N is presented on out_* after edge N+STAGES-1, i.e. visible STAGES cycles after its input cycle, with no stall.
- Throughput: 1 entry/cycle sustained with out_ready_i=1.
- Stall: with out_ready_i=0, the chain fills. in_ready_o=0 once all STAGES entries are valid.
- Outputs are driven directly from entry STAGES-1 registers; there is no combinational path from in_* to out_*.
- occ_o is registered and updates on the same edge as the entries.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: adds one skid entry ahead of entry 0.
  - in_ready_o = !flush_i & !skid_v, where skid_v is a register. This breaks the combinational path from out_ready_i.
  - An entry accepted while entry 0 is not free goes into the skid entry.
  - The skid entry drains into entry 0 with priority over new input.
  - Capacity is STAGES+1, and occ_o can reach STAGES+1.
  - Latency is unchanged when not stalled.
- Undefined: no skid logic. Capacity is STAGES, occ_o ≤ STAGES, and in_ready_o is combinational as above.

## Test plan
All scenarios use DATA_W=32, CTRL_W=3, STAGES=3 unless stated.
- Reset: hold rst_ni=0 for 2 edges with in_valid_i=1 -> out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0. After release, in_ready_o=1.
- Stream: feed data 0x11..0x15, ctrl 3'b101, out_ready_i=1 -> 0x11 appears on out_data_o 3 cycles after its input cycle. Then 0x12..0x15 appear on consecutive cycles; occ_o holds at 3.
- Backpressure: out_ready_i=0 while feeding 0xA0..0xA4 -> 3 accepted, in_ready_o=0 (no skid), occ_o=3. Raise out_ready_i -> 0xA0, 0xA1, ... appear in order, with no duplication.
- Bubble collapse: accept 0x01, skip 2 cycles, then accept 0x02 with out_ready_i=0 -> both entries sit in entries 2 and 1, occ_o=2, out_data_o=0x01.
- Flush: 2 entries in flight, pulse flush_i with out_ready_i=1 -> in_ready_o=0 that cycle and the shown entry transfers. Next cycle: out_valid_o=0, out_ctrl_o=0, occ_o=0.
- Skid (PIPE_STAGE_SKID_EN): out_ready_i=0, feed 0xB0..0xB5 -> 4 accepted, occ_o=4, in_ready_o=0 one cycle after the skid fills. Release -> 0xB0..0xB3 drain in order.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic pipeline register placed between core stages (EX/MEM, MEM/WB, ...).
//   It is a STAGES-deep chain of entries. Each entry has its own valid bit,
//   and the chain uses valid/ready backpressure with bubble collapsing and a
//   synchronous flush. Empty entries always hold all-zero ctrl/data, so an
//   empty entry looks like a NOP downstream.
//
//   Optional feature: `define PIPE_STAGE_SKID_EN adds one skid entry ahead of
//   entry 0. The skid entry registers in_ready_o, which removes the
//   combinational path from out_ready_i. It also raises capacity to STAGES+1.
//   The default build (macro undefined) has no skid entry.
//
// Parameters
//   DATA_W  datapath payload width
//   CTRL_W  control payload width (zero in empty entries)
//   STAGES  number of chain entries, 1..4
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   flush_i      squash every in-flight entry at the next edge
//   in_valid_i   upstream entry valid
//   in_ready_o   block accepts an entry this cycle
//   in_ctrl_i    upstream control payload
//   in_data_i    upstream data payload
//   out_valid_o  last entry valid
//   out_ready_i  downstream accepts the last entry
//   out_ctrl_o   last entry control (0 when out_valid_o=0)
//   out_data_o   last entry data    (0 when out_valid_o=0)
//   occ_o        registered count of valid entries, skid entry included

module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [CTRL_W-1:0]             in_ctrl_i,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CTRL_W-1:0]             out_ctrl_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [$clog2(STAGES+2)-1:0]   occ_o
);

  localparam int unsigned OCC_W = $clog2(STAGES + 2);

  // Chain state: index 0 is the input side, STAGES-1 drives the outputs.
  logic [STAGES-1:0] r_v;
  logic [CTRL_W-1:0] r_ctrl [STAGES];
  logic [DATA_W-1:0] r_data [STAGES];
  logic [OCC_W-1:0]  r_occ;

  logic [STAGES-1:0] w_free;
  logic [STAGES-1:0] w_v_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt [STAGES];
  logic [DATA_W-1:0] w_data_nxt [STAGES];
  logic [OCC_W-1:0]  w_occ_nxt;

  logic              w_in_fire;
  logic              w_src_v;
  logic [CTRL_W-1:0] w_src_ctrl;
  logic [DATA_W-1:0] w_src_data;

  // An entry is free when it is empty or its successor is free. The chain
  // is evaluated from the output side toward the input side. A running
  // scalar carries the result so that no vector feeds back on itself.
  always_comb begin : free_chain
    logic l_run;
    l_run            = ~r_v[STAGES-1] | out_ready_i;
    w_free           = '0;
    w_free[STAGES-1] = l_run;
    for (int unsigned i = 1; i < STAGES; i++) begin
      l_run                = ~r_v[STAGES-1-i] | l_run;
      w_free[STAGES-1-i]   = l_run;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_skid_v_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  // Ready depends only on the skid register, never on out_ready_i.
  assign in_ready_o = ~flush_i & ~r_skid_v;
  assign w_in_fire  = in_valid_i & in_ready_o;

  // A full skid entry always feeds entry 0 first. While the skid entry is
  // full, in_ready_o is low, so no new input competes for entry 0.
  always_comb begin
    w_src_v    = 1'b0;
    w_src_ctrl = '0;
    w_src_data = '0;
    if (r_skid_v) begin
      w_src_v    = 1'b1;
      w_src_ctrl = r_skid_ctrl;
      w_src_data = r_skid_data;
    end else if (w_in_fire) begin
      w_src_v    = 1'b1;
      w_src_ctrl = in_ctrl_i;
      w_src_data = in_data_i;
    end
  end

  always_comb begin
    w_skid_v_nxt    = r_skid_v;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush_i || (r_skid_v && w_free[0])) begin
      w_skid_v_nxt    = 1'b0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
    end else if (!r_skid_v && w_in_fire && !w_free[0]) begin
      w_skid_v_nxt    = 1'b1;
      w_skid_ctrl_nxt = in_ctrl_i;
      w_skid_data_nxt = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_skid_v    <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_skid_v    <= w_skid_v_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end
`else
  // Ready is combinational from out_ready_i through the free chain.
  assign in_ready_o = ~flush_i & w_free[0];
  assign w_in_fire  = in_valid_i & in_ready_o;

  always_comb begin
    w_src_v    = w_in_fire;
    w_src_ctrl = w_in_fire ? in_ctrl_i : '0;
    w_src_data = w_in_fire ? in_data_i : '0;
  end
`endif

  // Every free entry loads from its predecessor. Empty entries already hold
  // zeros, so copying an empty predecessor yields a clean NOP.
  always_comb begin
    w_v_nxt = r_v;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_ctrl_nxt[k] = r_ctrl[k];
      w_data_nxt[k] = r_data[k];
    end
    if (w_free[0]) begin
      w_v_nxt[0]    = w_src_v;
      w_ctrl_nxt[0] = w_src_ctrl;
      w_data_nxt[0] = w_src_data;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (w_free[k]) begin
        w_v_nxt[k]    = r_v[k-1];
        w_ctrl_nxt[k] = r_ctrl[k-1];
        w_data_nxt[k] = r_data[k-1];
      end
    end
    if (flush_i) begin
      w_v_nxt = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        w_ctrl_nxt[k] = '0;
        w_data_nxt[k] = '0;
      end
    end
  end

  // Occupancy is computed from next-state valids, so it updates on the
  // same edge as the entries.
  always_comb begin
    w_occ_nxt = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[k]);
    end
`ifdef PIPE_STAGE_SKID_EN
    w_occ_nxt = w_occ_nxt + OCC_W'(w_skid_v_nxt);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_occ_nxt;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= w_ctrl_nxt[k];
        r_data[k] <= w_data_nxt[k];
      end
    end
  end

  assign out_valid_o = r_v[STAGES-1];
  assign out_ctrl_o  = r_ctrl[STAGES-1];
  assign out_data_o  = r_data[STAGES-1];
  assign occ_o       = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (DATA_W=32, CTRL_W=3, STAGES=3).
// The reference model keeps in-flight items as a queue (oldest first).
// Each item carries its position in the chain, where -1 is the skid entry.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;
  localparam int STAGES = 3;
  localparam int OCC_W  = $clog2(STAGES + 2);
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [OCC_W-1:0]  occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAGES(STAGES)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_ctrl_i  (in_ctrl),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_ctrl_o (out_ctrl),
    .out_data_o (out_data),
    .occ_o      (occ)
  );

  typedef struct {
    int                pos;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the inputs, check the outputs against the model,
  // then advance the model across the edge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy);
    item_t             nq[$];
    item_t             n;
    int                lim;
    bit                busy0, had_skid, rdy_exp, exp_v;
    logic [CTRL_W-1:0] exp_c;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    rst_n = r; flush = f; in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    exp_v = 1'b0; exp_c = '0; exp_d = '0;
    if (q.size() > 0) begin
      if (q[0].pos == STAGES - 1) begin
        exp_v = 1'b1; exp_c = q[0].ctrl; exp_d = q[0].data;
      end
    end
    check_val("out_valid", out_valid, exp_v);
    check_val("out_ctrl", out_ctrl, exp_c);
    check_val("out_data", out_data, exp_d);
    check_val("occ", occ, q.size());
    lim = STAGES; busy0 = 0; had_skid = 0;
    foreach (q[i]) begin
      item_t it;
      it = q[i];
      if (it.pos == -1) had_skid = 1;
      if (i == 0 && it.pos == STAGES - 1 && ordy) continue;
      if (it.pos + 1 < lim) it.pos = it.pos + 1;
      lim = it.pos;
      if (it.pos == 0) busy0 = 1;
      nq.push_back(it);
    end
    rdy_exp = !f && (SKID ? !had_skid : !busy0);
    check_val("in_ready", in_ready, rdy_exp);
    if (v && rdy_exp) begin
      n.pos = busy0 ? -1 : 0; n.ctrl = c; n.data = d;
      nq.push_back(n);
    end
    @(posedge clk);
    if (!r || f) q.delete();
    else q = nq;
  endtask

  task automatic idle(input int cycles, input logic ordy);
    for (int i = 0; i < cycles; i++)
      step(1'b1, 1'b0, 1'b0, CTRL_W'($urandom), $urandom, ordy);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = '1;
    in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();

    // Reset held with valid input: nothing captured.
    step(1'b0, 1'b0, 1'b1, 3'b111, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
    #2 check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_occ", occ, 0);

    // Stream at full rate.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 3'b101, 32'h11 + i, 1'b1);
    #2 check_val("stream_occ", occ, 3);
    idle(4, 1'b1);

    // Backpressure until full, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 3'b010, 32'hA0 + i, 1'b0);
    #2 check_val("bp_occ", occ, SKID ? 4 : 3);
    check_val("bp_in_ready", in_ready, 1'b0);
    idle(6, 1'b1);

    // Bubble collapse while downstream is stalled.
    step(1'b1, 1'b0, 1'b1, 3'b001, 32'h01, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'b011, 32'h02, 1'b0);
    idle(1, 1'b0);
    #2 check_val("bubble_occ", occ, 2);
    check_val("bubble_data", out_data, 32'h01);
    idle(4, 1'b1);

    // Flush with an output handshake in the same cycle.
    step(1'b1, 1'b0, 1'b1, 3'b110, 32'h31, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'b111, 32'h32, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'b100, 32'h33, 1'b1);
    #2 check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_ctrl", out_ctrl, 3'b000);
    check_val("flush_occ", occ, 0);

`ifdef PIPE_STAGE_SKID_EN
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 3'b101, 32'hB0 + i, 1'b0);
    #2 check_val("skid_occ", occ, 4);
    idle(6, 1'b1);
`endif

    // Randomized traffic: occasional reset and flush, biased ready.
    for (int i = 0; i < 3000; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(0, 199) != 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(r, f, v, CTRL_W'($urandom), $urandom, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
